// File: rtl/game_pkg.sv
// Shared fight-screen constants: game state codes, last visible pixel, hit FSM encoding.
package game_pkg;

  localparam logic [3:0] ST_MENU  = 4'd0;
  localparam logic [3:0] ST_FIGHT = 4'd1;

  localparam logic [9:0] H_LAST = 10'd639;
  localparam logic [9:0] V_LAST = 10'd479;

  typedef enum logic [1:0] {
    HitIdle   = 2'd0,
    HitArmed  = 2'd1,
    HitInvuln = 2'd2,
    HitDead   = 2'd3
  } hit_state_e;

endpackage

// File: rtl/frame_tick.sv
// One-cycle frameEnd pulse on the first cycle the scan sits on the last visible pixel.
module frame_tick
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       frameEnd
);

  logic at_last;
  logic at_last_d, at_last_q;

  always_comb begin
    at_last   = (x == H_LAST) && (y == V_LAST);
    at_last_d = at_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      at_last_q <= 1'b0;
    end else begin
      at_last_q <= at_last_d;
    end
  end

  // Edge-detect so a stalled scan cannot produce more than one frame end.
  assign frameEnd = at_last & ~at_last_q;

endmodule

// File: rtl/hit_hp_ctrl.sv
// Heart/bullet collision judge and HP keeper: per-pixel hits, once-per-frame damage, invuln, death.
// Define HP_REGEN_EN to add slow HP regeneration while armed.
module hit_hp_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_BULLETS   = 3,
  parameter int unsigned MAX_HP        = 20,
  parameter int unsigned DAMAGE        = 3,
  parameter int unsigned INVULN_FRAMES = 30
`ifdef HP_REGEN_EN
  ,
  parameter int unsigned REGEN_FRAMES  = 120
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             state,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic                   heartSpriteOn,
  input  logic [NUM_BULLETS-1:0] bulletSpriteOn,
  output logic [NUM_BULLETS-1:0] collision,
  output logic [6:0]             hp,
  output logic                   hitFlash,
  output logic                   gameOver
);

  localparam logic [6:0] MaxHp   = 7'(MAX_HP);
  localparam logic [6:0] DmgHp   = 7'(DAMAGE);
  localparam logic [7:0] InvLoad = 8'(INVULN_FRAMES);

`ifdef HP_REGEN_EN
  localparam int unsigned RegenW = $clog2(REGEN_FRAMES + 1);
  localparam logic [RegenW-1:0] RegenLast = RegenW'(REGEN_FRAMES - 1);
  localparam logic [RegenW-1:0] RegenOne  = RegenW'(1);

  logic [RegenW-1:0] regen_d, regen_q;
`endif

  logic                   frame_end;
  logic [NUM_BULLETS-1:0] ov;
  logic                   qual;
  logic                   any_hit;

  hit_state_e             fsm_d, fsm_q;
  logic [6:0]             hp_d, hp_q;
  logic                   hit_acc_d, hit_acc_q;
  logic [7:0]             inv_cnt_d, inv_cnt_q;
  logic [NUM_BULLETS-1:0] coll_d, coll_q;

  frame_tick u_frame_tick (
    .clk      (clk),
    .reset    (reset),
    .x        (x),
    .y        (y),
    .frameEnd (frame_end)
  );

  always_comb begin
    ov      = {NUM_BULLETS{heartSpriteOn}} & bulletSpriteOn;
    qual    = (state == ST_FIGHT) && (fsm_q == HitArmed);
    // A hit on the very last pixel still belongs to the frame ending this cycle.
    any_hit = hit_acc_q | (qual & (|ov));

    fsm_d     = fsm_q;
    hp_d      = hp_q;
    hit_acc_d = hit_acc_q;
    inv_cnt_d = inv_cnt_q;
    coll_d    = '0;
`ifdef HP_REGEN_EN
    regen_d   = regen_q;
`endif

    if (state == ST_MENU) begin
      fsm_d     = HitIdle;
      hp_d      = MaxHp;
      hit_acc_d = 1'b0;
      inv_cnt_d = '0;
`ifdef HP_REGEN_EN
      regen_d   = '0;
`endif
    end else if (state == ST_FIGHT) begin
      if (qual) begin
        coll_d = ov;
      end
      hit_acc_d = any_hit;

      unique case (fsm_q)
        HitIdle: fsm_d = HitArmed;
        HitArmed: begin
          if (frame_end) begin
            if (any_hit) begin
              if (hp_q > DmgHp) begin
                hp_d      = hp_q - DmgHp;
                fsm_d     = HitInvuln;
                inv_cnt_d = InvLoad;
              end else begin
                hp_d  = '0;
                fsm_d = HitDead;
              end
`ifdef HP_REGEN_EN
              regen_d = '0;
            end else if (regen_q == RegenLast) begin
              regen_d = '0;
              if (hp_q < MaxHp) begin
                hp_d = hp_q + 7'd1;
              end
            end else begin
              regen_d = regen_q + RegenOne;
`endif
            end
          end
        end
        HitInvuln: begin
          if (frame_end) begin
            if (inv_cnt_q <= 8'd1) begin
              fsm_d     = HitArmed;
              inv_cnt_d = '0;
            end else begin
              inv_cnt_d = inv_cnt_q - 8'd1;
            end
          end
        end
        HitDead: fsm_d = HitDead;
      endcase

      if (frame_end) begin
        hit_acc_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= HitIdle;
      hp_q      <= MaxHp;
      hit_acc_q <= 1'b0;
      inv_cnt_q <= '0;
      coll_q    <= '0;
`ifdef HP_REGEN_EN
      regen_q   <= '0;
`endif
    end else begin
      fsm_q     <= fsm_d;
      hp_q      <= hp_d;
      hit_acc_q <= hit_acc_d;
      inv_cnt_q <= inv_cnt_d;
      coll_q    <= coll_d;
`ifdef HP_REGEN_EN
      regen_q   <= regen_d;
`endif
    end
  end

  assign collision = coll_q;
  assign hp        = hp_q;
  assign hitFlash  = (fsm_q == HitInvuln);
  assign gameOver  = (fsm_q == HitDead);

endmodule

// File: tb/tb_hit_hp_ctrl.sv
// Self-checking bench for hit_hp_ctrl: vector table, directed sequences, randomized scan vs model.
module tb_hit_hp_ctrl;

  localparam int MAXHP = 20;
  localparam int DMG   = 3;
  localparam int INV   = 30;
  localparam int REGEN = 120;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state;
  logic [9:0] x, y;
  logic       heart;
  logic [2:0] bul;
  logic [2:0] coll;
  logic [6:0] hp;
  logic       flash, over;

  always #5 clk = ~clk;

  hit_hp_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .state          (state),
    .x              (x),
    .y              (y),
    .heartSpriteOn  (heart),
    .bulletSpriteOn (bul),
    .collision      (coll),
    .hp             (hp),
    .hitFlash       (flash),
    .gameOver       (over)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: HP, remaining invulnerable frames, death flag, per-frame hit memory.
  int m_hp, m_inv, m_regen, m_coll;
  bit m_active, m_dead, m_acc;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_hp = MAXHP; m_inv = 0; m_regen = 0; m_coll = 0;
    m_active = 0; m_dead = 0; m_acc = 0;
  endtask

  task automatic m_step(input int st, input int xx, input int yy, input bit h, input int b);
    int ov;
    bit fe;
    bit vuln;
    ov = h ? b : 0;
    fe = (xx == 639) && (yy == 479);
    m_coll = 0;
    if (st == 0) begin
      m_reset();
    end else if (st == 1) begin
      if (!m_active) begin
        m_active = 1;
      end else begin
        vuln = !m_dead && (m_inv == 0);
        if (vuln && ov != 0) begin
          m_coll = ov;
          m_acc  = 1;
        end
        if (fe && !m_dead) begin
          if (m_inv > 0) begin
            m_inv--;
          end else if (m_acc) begin
            m_regen = 0;
            if (m_hp > DMG) begin
              m_hp  = m_hp - DMG;
              m_inv = INV;
            end else begin
              m_hp   = 0;
              m_dead = 1;
            end
          end else begin
`ifdef HP_REGEN_EN
            m_regen++;
            if (m_regen == REGEN) begin
              m_regen = 0;
              if (m_hp < MAXHP) m_hp++;
            end
`endif
          end
        end
        if (fe) m_acc = 0;
      end
    end
  endtask

  task automatic px(input int st, input int xx, input int yy, input bit h, input int b);
    @(negedge clk);
    state = 4'(st); x = 10'(xx); y = 10'(yy); heart = h; bul = 3'(b);
    m_step(st, xx, yy, h, b);
    @(posedge clk);
    #1;
    chk("collision", int'(coll), m_coll);
    chk("hp", int'(hp), m_hp);
    chk("hitFlash", int'(flash), int'(!m_dead && m_inv > 0));
    chk("gameOver", int'(over), int'(m_dead));
  endtask

  // Compressed frame: a couple of interior pixels then the last visible pixel.
  task automatic frame(input int st, input int mask);
    px(st, 10, 10, 1'b1, mask);
    px(st, 11, 10, 1'b0, 0);
    px(st, 639, 479, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; state = 4'd1; x = '0; y = '0; heart = 1'b0; bul = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hp", int'(hp), MAXHP);
    chk("rst_collision", int'(coll), 0);
    chk("rst_hitFlash", int'(flash), 0);
    chk("rst_gameOver", int'(over), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int st; int xx; int yy; bit h; int b;
    int e_coll; int e_hp; bit e_flash; bit e_over;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int pulses;
    int n;
    int exp_hp;

    vecs[0]  = '{1,   0,   0, 1'b0, 0, 0, 20, 1'b0, 1'b0};
    vecs[1]  = '{1,   1,   0, 1'b1, 1, 1, 20, 1'b0, 1'b0};
    vecs[2]  = '{1,   2,   0, 1'b1, 5, 5, 20, 1'b0, 1'b0};
    vecs[3]  = '{1,   3,   0, 1'b0, 2, 0, 20, 1'b0, 1'b0};
    vecs[4]  = '{1, 639, 479, 1'b1, 0, 0, 17, 1'b1, 1'b0};
    vecs[5]  = '{1,   0,   0, 1'b1, 7, 0, 17, 1'b1, 1'b0};
    vecs[6]  = '{2, 639, 479, 1'b1, 1, 0, 17, 1'b1, 1'b0};
    vecs[7]  = '{0,   5,   5, 1'b0, 0, 0, 20, 1'b0, 1'b0};
    vecs[8]  = '{1,   5,   6, 1'b0, 0, 0, 20, 1'b0, 1'b0};
    vecs[9]  = '{1, 639, 479, 1'b1, 2, 2, 17, 1'b1, 1'b0};
    vecs[10] = '{0,   0,   0, 1'b0, 0, 0, 20, 1'b0, 1'b0};
    vecs[11] = '{1,   1,   1, 1'b0, 0, 0, 20, 1'b0, 1'b0};
    vecs[12] = '{2,   2,   2, 1'b1, 1, 0, 20, 1'b0, 1'b0};
    vecs[13] = '{1, 639, 479, 1'b0, 0, 0, 20, 1'b0, 1'b0};

    reset = 1'b1; state = '0; x = '0; y = '0; heart = 1'b0; bul = '0;

    // Idle fight: two clean frames leave everything at reset values.
    do_reset();
    frame(1, 0);
    frame(1, 0);
    chk("clean_hp", int'(hp), 20);
    chk("clean_flash", int'(flash), 0);

    // Vector table.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      px(vecs[i].st, vecs[i].xx, vecs[i].yy, vecs[i].h, vecs[i].b);
      chk($sformatf("vec%0d_coll", i), int'(coll), vecs[i].e_coll);
      chk($sformatf("vec%0d_hp", i), int'(hp), vecs[i].e_hp);
      chk($sformatf("vec%0d_flash", i), int'(flash), int'(vecs[i].e_flash));
      chk($sformatf("vec%0d_over", i), int'(over), int'(vecs[i].e_over));
    end

    // Four overlapping pixels in frame 5, then exactly INV invulnerable frame ends.
    do_reset();
    px(1, 0, 0, 1'b0, 0);
    repeat (4) frame(1, 0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      px(1, 100 + k, 50, 1'b1, 1);
      if (coll[0]) pulses++;
    end
    px(1, 639, 479, 1'b0, 0);
    chk("pulse_count", pulses, 4);
    chk("hit_hp", int'(hp), 17);
    chk("hit_flash", int'(flash), 1);
    n = 0;
    while (flash && n < 40) begin
      frame(1, 0);
      n++;
    end
    chk("invuln_frames", n, INV);

    // Two bullets on one pixel: both bits pulse, single damage.
    px(1, 5, 5, 1'b1, 5);
    chk("dual_coll", int'(coll), 5);
    px(1, 639, 479, 1'b0, 0);
    chk("dual_hp", int'(hp), 14);
    repeat (INV) frame(1, 0);
    chk("dual_rearmed", int'(flash), 0);

    // Seven spaced hits drain HP to zero.
    do_reset();
    px(1, 0, 0, 1'b0, 0);
    for (int k = 1; k <= 7; k++) begin
      frame(1, 1);
      exp_hp = (MAXHP - DMG * k > 0) ? MAXHP - DMG * k : 0;
      chk($sformatf("drain%0d_hp", k), int'(hp), exp_hp);
      chk($sformatf("drain%0d_over", k), int'(over), int'(k == 7));
      if (k < 7) repeat (INV + 1) frame(1, 0);
    end
    frame(1, 7);
    chk("dead_hp", int'(hp), 0);
    px(0, 20, 20, 1'b0, 0);
    chk("menu_hp", int'(hp), MAXHP);
    chk("menu_over", int'(over), 0);

    // Regeneration (or its absence), then a frozen hold state.
    do_reset();
    px(1, 0, 0, 1'b0, 0);
    frame(1, 2);
    repeat (INV) frame(1, 0);
    repeat (REGEN - 1) frame(1, 0);
    chk("regen_pre_hp", int'(hp), 17);
    frame(1, 0);
`ifdef HP_REGEN_EN
    chk("regen_hp", int'(hp), 18);
`else
    chk("regen_hp", int'(hp), 17);
`endif
    exp_hp = int'(hp);
    repeat (REGEN + 10) frame(2, 1);
    chk("hold_hp", int'(hp), exp_hp);
    chk("hold_flash", int'(flash), 0);

    // Full HP stays capped over many clean frames.
    do_reset();
    px(1, 0, 0, 1'b0, 0);
    repeat (REGEN + 10) frame(1, 0);
    chk("cap_hp", int'(hp), MAXHP);

    // Randomized scan against the model.
    do_reset();
    for (int f = 0; f < 1500; f++) begin
      int np;
      np = int'($urandom_range(1, 4));
      for (int p = 0; p < np; p++) begin
        int r;
        int st;
        r  = int'($urandom_range(0, 99));
        st = (r < 1) ? 0 : (r < 4) ? 2 : 1;
        px(st, int'($urandom_range(0, 638)), int'($urandom_range(0, 478)),
           ($urandom_range(0, 15) == 0), int'($urandom_range(0, 7)));
      end
      px(($urandom_range(0, 19) == 0) ? 2 : 1, 639, 479,
         ($urandom_range(0, 15) == 0), int'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
